// File: rtl/bubble_pkg.sv
// Shared definitions for the bubble control protocol: sequencer state encoding, bubble-cycle
// timing constants, counter widths and the 4-bit control codes that the timing generator decodes.
// Code bit order is {nBSS, nBOOTEN, nBSEN, nREPEN}.
package bubble_pkg;

  localparam int unsigned CYCLE_CLKS     = 480;   // MCLK per bubble cycle (10 us at 48 MHz)
  localparam int unsigned SETUP_CLKS     = 96;
  localparam int unsigned BSS_PULSE_CLKS = 48;
  localparam int unsigned REP_PULSE_CLKS = 48;
  localparam int unsigned BOOT_CYCLES    = 4204;  // 98 invalid + 2053*2 valid
  localparam int unsigned PAGE_CYCLES    = 682;   // 98 invalid + 584 valid

  localparam int unsigned CLK_CNT_W = 10;
  localparam int unsigned CYC_CNT_W = 13;

  localparam logic [3:0] ACC_STBY = 4'b0011;
  localparam logic [3:0] ACC_BOOT = 4'b1001;
  localparam logic [3:0] ACC_IDLE = 4'b0111;
  localparam logic [3:0] ACC_USER = 4'b1100;

  typedef enum logic [3:0] {
    StIdle,
    StSetup,
    StBss,
    StGap,
    StBsen,
    StSeek,
    StRep,
    StHold,
    StRel
  } seq_state_e;

endpackage

// File: rtl/bubble_cycle_counter.sv
// Bubble timing counter: an MCLK-within-cycle counter that wraps at CycleClks-1 and carries into
// a bubble-cycle counter.
//  MCLK, nRESET : clock, asynchronous active-low reset
//  clear_i      : synchronous clear of both counters (wins over en_i)
//  en_i         : count enable
//  target_i     : bubble-cycle count to reach
//  clk_cnt_o    : MCLK-within-cycle count, also used by the sequencer for short waits
//  tc_o         : high in the MCLK whose closing edge completes target_i whole bubble cycles
module bubble_cycle_counter #(
  parameter int unsigned CycleClks = bubble_pkg::CYCLE_CLKS
) (
  input  logic                             MCLK,
  input  logic                             nRESET,
  input  logic                             clear_i,
  input  logic                             en_i,
  input  logic [bubble_pkg::CYC_CNT_W-1:0] target_i,
  output logic [bubble_pkg::CLK_CNT_W-1:0] clk_cnt_o,
  output logic                             tc_o
);
  import bubble_pkg::*;

  localparam logic [CLK_CNT_W-1:0] ClkLast = CLK_CNT_W'(CycleClks - 1);

  logic [CLK_CNT_W-1:0] clk_cnt_q;
  logic [CYC_CNT_W-1:0] cyc_cnt_q;

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      clk_cnt_q <= '0;
      cyc_cnt_q <= '0;
    end else if (clear_i) begin
      clk_cnt_q <= '0;
      cyc_cnt_q <= '0;
    end else if (en_i) begin
      if (clk_cnt_q == ClkLast) begin
        clk_cnt_q <= '0;
        cyc_cnt_q <= cyc_cnt_q + CYC_CNT_W'(1);
      end else begin
        clk_cnt_q <= clk_cnt_q + CLK_CNT_W'(1);
      end
    end
  end

  assign clk_cnt_o = clk_cnt_q;
  // Fires one MCLK early so the registered control edge lands exactly on the cycle boundary.
  assign tc_o = en_i && (clk_cnt_q == ClkLast) && ((cyc_cnt_q + CYC_CNT_W'(1)) == target_i);

endmodule

// File: rtl/bubble_host_sequencer.sv
// Host-side bubble control sequencer. A one-MCLK boot or page request starts a timed sequence on
// the nINCTRL/nBSS/nBSEN/nREPEN/nBOOTEN lines; every output is registered.
//  MCLK, nRESET      : master clock, asynchronous active-low reset
//  REQ_BOOT/REQ_PAGE : start strobes (boot wins when both are high)
//  SEEK_CYCLES       : bubble cycles from nBSEN fall to nREPEN fall, latched on accept
//  ABORT             : level, ends an active sequence through the release gap
//  nINCTRL, nBSS, nBSEN, nREPEN, nBOOTEN : active-low bubble controls
//  BUSY              : accept until return to idle
//  DONE              : one-MCLK pulse at completion or after an abort
module bubble_host_sequencer #(
  parameter int unsigned CYCLE_CLKS     = bubble_pkg::CYCLE_CLKS,
  parameter int unsigned SETUP_CLKS     = bubble_pkg::SETUP_CLKS,
  parameter int unsigned BSS_PULSE_CLKS = bubble_pkg::BSS_PULSE_CLKS,
  parameter int unsigned REP_PULSE_CLKS = bubble_pkg::REP_PULSE_CLKS,
  parameter int unsigned BOOT_CYCLES    = bubble_pkg::BOOT_CYCLES,
  parameter int unsigned PAGE_CYCLES    = bubble_pkg::PAGE_CYCLES
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        REQ_BOOT,
  input  logic        REQ_PAGE,
  input  logic [11:0] SEEK_CYCLES,
  input  logic        ABORT,
  output logic        nINCTRL,
  output logic        nBSS,
  output logic        nBSEN,
  output logic        nREPEN,
  output logic        nBOOTEN,
  output logic        BUSY,
  output logic        DONE
);
  import bubble_pkg::*;

  localparam logic [CLK_CNT_W-1:0] SetupLast = CLK_CNT_W'(SETUP_CLKS - 1);
  localparam logic [CLK_CNT_W-1:0] BssLast   = CLK_CNT_W'(BSS_PULSE_CLKS - 1);
  localparam logic [CLK_CNT_W-1:0] RepLast   = CLK_CNT_W'(REP_PULSE_CLKS - 1);
  localparam logic [CYC_CNT_W-1:0] BootTgt   = CYC_CNT_W'(BOOT_CYCLES);
  localparam logic [CYC_CNT_W-1:0] PageTgt   = CYC_CNT_W'(PAGE_CYCLES);

  seq_state_e           state_q;
  logic                 boot_q;
  logic [11:0]          seek_q;

  logic [CLK_CNT_W-1:0] clk_cnt;
  logic [CLK_CNT_W-1:0] wait_last;
  logic [CYC_CNT_W-1:0] target;
  logic                 wait_done;
  logic                 tc;
  logic                 abort_hit;
  logic                 cnt_clear;

  assign abort_hit = ABORT && (state_q != StIdle) && (state_q != StRel);

  always_comb begin
    wait_last = SetupLast;
    case (state_q)
      StBss:   wait_last = BssLast;
      StRep:   wait_last = RepLast;
      default: wait_last = SetupLast;
    endcase
  end

  assign wait_done = (clk_cnt == wait_last);
  assign target    = (state_q == StHold) ? (boot_q ? BootTgt : PageTgt) : {1'b0, seek_q};

  // Counter restarts on entry to every timed phase. The BSEN->HOLD (boot) and BSEN->SEEK (page)
  // hops keep counting so bubble cycles are measured from the nBSEN fall itself.
  always_comb begin
    cnt_clear = 1'b0;
    case (state_q)
      StIdle:                              cnt_clear = 1'b1;
      StSetup, StBss, StGap, StRep, StRel: cnt_clear = wait_done;
      StBsen:                              cnt_clear = !boot_q && (seek_q == '0);
      StSeek, StHold:                      cnt_clear = tc;
      default:                             cnt_clear = 1'b1;
    endcase
    if (abort_hit) cnt_clear = 1'b1;
  end

  bubble_cycle_counter #(
    .CycleClks (CYCLE_CLKS)
  ) u_counter (
    .MCLK      (MCLK),
    .nRESET    (nRESET),
    .clear_i   (cnt_clear),
    .en_i      (1'b1),
    .target_i  (target),
    .clk_cnt_o (clk_cnt),
    .tc_o      (tc)
  );

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
      boot_q  <= 1'b0;
      seek_q  <= '0;
      nINCTRL <= 1'b1;
      nBSS    <= 1'b1;
      nBSEN   <= 1'b1;
      nREPEN  <= 1'b1;
      nBOOTEN <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (abort_hit) begin
        nBSS    <= 1'b1;
        nBSEN   <= 1'b1;
        nREPEN  <= 1'b1;
        state_q <= StRel;
      end else begin
        unique case (state_q)
          StIdle: begin
            // A held ABORT also blocks a new accept.
            if (!ABORT && (REQ_BOOT || REQ_PAGE)) begin
              state_q <= StSetup;
              boot_q  <= REQ_BOOT;
              seek_q  <= SEEK_CYCLES;
              nINCTRL <= 1'b0;
              nBOOTEN <= !REQ_BOOT;
              BUSY    <= 1'b1;
            end
          end
          StSetup: if (wait_done) begin
            nBSS    <= 1'b0;
            state_q <= StBss;
          end
          StBss: if (wait_done) begin
            nBSS    <= 1'b1;
            state_q <= StGap;
          end
          StGap: if (wait_done) begin
            nBSEN   <= 1'b0;
            state_q <= StBsen;
          end
          StBsen: begin
            if (boot_q) begin
              state_q <= StHold;
            end else if (seek_q == '0) begin
              nREPEN  <= 1'b0;
              state_q <= StRep;
            end else begin
              state_q <= StSeek;
            end
          end
          StSeek: if (tc) begin
            nREPEN  <= 1'b0;
            state_q <= StRep;
          end
          StRep: if (wait_done) begin
            nREPEN  <= 1'b1;
            state_q <= StHold;
          end
          StHold: if (tc) begin
            nBSEN   <= 1'b1;
            state_q <= StRel;
          end
          StRel: if (wait_done) begin
            nINCTRL <= 1'b1;
            nBOOTEN <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bubble_host_sequencer.sv
// Bench for bubble_host_sequencer with shortened timing parameters. Expected waveforms come from
// event times derived from the protocol rules (edge offsets after the accept edge).
module tb_bubble_host_sequencer;
  import bubble_pkg::*;

  localparam int C  = 10;  // MCLK per bubble cycle
  localparam int S  = 6;   // setup / gap
  localparam int B  = 3;   // nBSS width
  localparam int R  = 2;   // nREPEN width
  localparam int BC = 5;   // boot cycles
  localparam int PC = 4;   // page cycles
  localparam logic [6:0] IdleVec = 7'b1111100;

  logic        MCLK = 1'b0;
  logic        nRESET;
  logic        REQ_BOOT, REQ_PAGE, ABORT;
  logic [11:0] SEEK_CYCLES;
  logic        nINCTRL, nBSS, nBSEN, nREPEN, nBOOTEN, BUSY, DONE;

  int n_assert = 0;
  int n_fail   = 0;

  bubble_host_sequencer #(
    .CYCLE_CLKS     (C),
    .SETUP_CLKS     (S),
    .BSS_PULSE_CLKS (B),
    .REP_PULSE_CLKS (R),
    .BOOT_CYCLES    (BC),
    .PAGE_CYCLES    (PC)
  ) dut (
    .MCLK        (MCLK),
    .nRESET      (nRESET),
    .REQ_BOOT    (REQ_BOOT),
    .REQ_PAGE    (REQ_PAGE),
    .SEEK_CYCLES (SEEK_CYCLES),
    .ABORT       (ABORT),
    .nINCTRL     (nINCTRL),
    .nBSS        (nBSS),
    .nBSEN       (nBSEN),
    .nREPEN      (nREPEN),
    .nBOOTEN     (nBOOTEN),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  always #5 MCLK = ~MCLK;

  function automatic logic [6:0] obs();
    return {nINCTRL, nBSS, nBSEN, nREPEN, nBOOTEN, BUSY, DONE};
  endfunction

  task automatic check(input string tag, input int k, input logic [6:0] o, input logic [6:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, o, e);
    end
  endtask

  // Offset of the nBSEN rise after the accept edge, absent abort.
  function automatic int bsen_rise(input bit boot, input int seek);
    int tb  = 2 * S + B;
    int trf = tb + ((seek == 0) ? 1 : seek * C);
    return boot ? (tb + BC * C) : (trf + R + PC * C);
  endfunction

  // Expected {nINCTRL,nBSS,nBSEN,nREPEN,nBOOTEN,BUSY,DONE} after edge k (k=0 is the accept edge).
  function automatic logic [6:0] model(input int k, input bit boot, input int seek, input int ka);
    int  tb  = 2 * S + B;
    int  trf = tb + ((seek == 0) ? 1 : seek * C);
    int  trr = trf + R;
    int  tbr = bsen_rise(boot, seek);
    bit  ab  = (ka > 0) && (ka <= tbr);
    int  cut = ab ? ka : (1 << 30);
    int  td  = (ab ? ka : tbr) + S;
    logic act, nbss, nbsen, nrep;
    act   = (k < td);
    nbss  = !(k >= S && k < S + B && k < cut);
    nbsen = !(k >= tb && k < tbr && k < cut);
    nrep  = boot ? 1'b1 : !(k >= trf && k < trr && k < cut);
    return {!act, nbss, nbsen, nrep, !(boot && act), act, (k == td)};
  endfunction

  task automatic run_txn(input bit rb, input bit rp, input int seek, input int ka, input bit poke);
    bit boot = rb;
    int tb   = 2 * S + B;
    int trf  = tb + ((seek == 0) ? 1 : seek * C);
    int tbr  = bsen_rise(rb, seek);
    int cut  = ((ka > 0) && (ka <= tbr)) ? ka : (1 << 30);
    int td   = (((ka > 0) && (ka <= tbr)) ? ka : tbr) + S;
    logic [3:0] code;
    @(posedge MCLK); #1;
    REQ_BOOT    = rb;
    REQ_PAGE    = rp;
    SEEK_CYCLES = 12'(seek);
    @(posedge MCLK); #1;  // accept edge
    REQ_BOOT    = 1'b0;
    REQ_PAGE    = 1'b0;
    SEEK_CYCLES = 12'($urandom_range(0, 4095));
    for (int k = 0; k <= td + 1; k++) begin
      ABORT = (k + 1 == ka);
      if (poke && (k + 1 <= td)) begin
        REQ_BOOT    = ($urandom_range(0, 5) == 0);
        REQ_PAGE    = ($urandom_range(0, 5) == 0);
        SEEK_CYCLES = 12'($urandom_range(0, 4095));
      end else begin
        REQ_BOOT = 1'b0;
        REQ_PAGE = 1'b0;
      end
      @(negedge MCLK);
      check(boot ? "boot_seq" : "page_seq", k, obs(), model(k, boot, seek, ka));
      code = {nBSS, nBOOTEN, nBSEN, nREPEN};
      if (k == S && S < cut)
        check("code_first", k, {3'b0, code}, {3'b0, boot ? ACC_STBY : ACC_IDLE});
      if (boot && k == tb && tb < cut)
        check("code_boot", k, {3'b0, code}, {3'b0, ACC_BOOT});
      if (!boot && k == trf && trf < cut)
        check("code_user", k, {3'b0, code}, {3'b0, ACC_USER});
      @(posedge MCLK); #1;
    end
    REQ_BOOT = 1'b0;
    REQ_PAGE = 1'b0;
    ABORT    = 1'b0;
  endtask

  initial begin
    nRESET      = 1'b0;
    REQ_BOOT    = 1'b0;
    REQ_PAGE    = 1'b0;
    ABORT       = 1'b0;
    SEEK_CYCLES = '0;
    #12;
    check("reset", 0, obs(), IdleVec);
    @(negedge MCLK);
    nRESET = 1'b1;

    // ABORT in idle blocks a simultaneous request.
    @(posedge MCLK); #1;
    ABORT    = 1'b1;
    REQ_BOOT = 1'b1;
    @(posedge MCLK); #1;
    ABORT    = 1'b0;
    REQ_BOOT = 1'b0;
    @(negedge MCLK);
    check("abort_idle", 0, obs(), IdleVec);

    run_txn(1'b1, 1'b0, 0, 0, 1'b1);           // boot, strobes while busy
    run_txn(1'b0, 1'b1, 2, 0, 1'b1);           // page, seek 2
    run_txn(1'b0, 1'b1, 0, 0, 1'b0);           // page, seek 0
    run_txn(1'b1, 1'b1, 3, 0, 1'b0);           // both strobes: boot wins
    run_txn(1'b0, 1'b1, 3, 2 * S + B + 12, 1'b0);  // abort during seek
    run_txn(1'b1, 1'b0, 0, S + 1, 1'b0);       // abort during nBSS pulse

    for (int i = 0; i < 6; i++) begin
      bit rb   = 1'($urandom_range(0, 1));
      bit rp   = rb ? 1'($urandom_range(0, 1)) : 1'b1;
      int seek = $urandom_range(0, 3);
      int ka   = ($urandom_range(0, 2) == 0) ?
                 int'($urandom_range(1, bsen_rise(rb, seek) + S)) : 0;
      run_txn(rb, rp, seek, ka, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the boot hold phase.
    @(posedge MCLK); #1;
    REQ_BOOT = 1'b1;
    @(posedge MCLK); #1;
    REQ_BOOT = 1'b0;
    repeat (2 * S + B + 10) @(posedge MCLK);
    @(negedge MCLK);
    check("pre_rst_hold", 0, obs(), model(2 * S + B + 10, 1'b1, 0, 0));
    #2 nRESET = 1'b0;
    #1 check("async_rst", 0, obs(), IdleVec);
    for (int i = 0; i < 3; i++) begin
      @(negedge MCLK);
      check("rst_low", i, obs(), IdleVec);
    end
    nRESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge MCLK);
      check("post_rst", i, obs(), IdleVec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
